// File: rtl/bram_req_seq.sv
// bram_req_seq: turns a merged request token stream into single-port BRAM
// traffic. A header token selects a store burst (following tokens are written
// to consecutive addresses) or a load burst (reads are issued and returned as
// an output token stream, last word flagged).
//
// Ports
//   clock, reset             clock, asynchronous active-low reset
//   I_FTk_v/a/r/d, O_BTk_n   inbound tokens (valid/header/last/data), nack back
//   O_FTk_v/r/d, I_BTk_n     load data stream (valid/last/data), downstream nack
//   O_Mem_En/We/Addr/Wd      BRAM command, I_Mem_Rd returns one cycle after a read
//   O_Busy, O_Err            request in progress, one-cycle error pulse
module bram_req_seq #(
   parameter int unsigned WIDTH_DATA = 32,
   parameter int unsigned WIDTH_ADDR = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  I_FTk_v,
   input  logic                  I_FTk_a,
   input  logic                  I_FTk_r,
   input  logic [WIDTH_DATA-1:0] I_FTk_d,
   output logic                  O_BTk_n,
   output logic                  O_FTk_v,
   output logic                  O_FTk_r,
   output logic [WIDTH_DATA-1:0] O_FTk_d,
   input  logic                  I_BTk_n,
   output logic                  O_Mem_En,
   output logic                  O_Mem_We,
   output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
   output logic [WIDTH_DATA-1:0] O_Mem_Wd,
   input  logic [WIDTH_DATA-1:0] I_Mem_Rd,
   output logic                  O_Busy,
   output logic                  O_Err
);

   localparam int unsigned LEN_W = 12;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {IDLE, STORE, LOAD, DRAIN} state_t;

   typedef struct packed {
      logic                  last;
      logic [WIDTH_DATA-1:0] data;
   } rd_word_t;

   state_t                state_q, state_next;
   logic [WIDTH_ADDR-1:0] addr_q, addr_next;
   logic [LEN_W-1:0]      rem_q, rem_next;
   logic                  mem_last_q;
   logic                  rd_ret_q, rd_ret_last_q;

   rd_word_t              fifo_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      cnt_q, cnt_next;

   logic                  tok_acc, st_acc, issue, issue_last, err;
   logic [WIDTH_ADDR-1:0] issue_addr;
   logic                  rd_now, xfer, out_free, push, pop, bypass, can_issue;

   logic                  hdr_we;
   logic [LEN_W-1:0]      hdr_len;
   logic [WIDTH_ADDR-1:0] hdr_base;

   assign hdr_we   = I_FTk_d[31];
   assign hdr_len  = I_FTk_d[27:16];
   assign hdr_base = I_FTk_d[WIDTH_ADDR-1:0];

   // Read return path: FIFO bookkeeping, output-register bypass and issue gate
   always_comb begin
      rd_now   = O_Mem_En & ~O_Mem_We;
      xfer     = O_FTk_v & ~I_BTk_n;
      out_free = ~O_FTk_v | xfer;
      pop      = out_free & (cnt_q != '0);
      bypass   = out_free & (cnt_q == '0) & rd_ret_q;
      push     = rd_ret_q & ~bypass;
      cnt_next = CNT_W'(cnt_q + CNT_W'(push) - CNT_W'(pop));
      // FIFO slots still free must cover the read on the BRAM port now
      // plus the one about to be issued, whatever I_BTk_n does next.
      can_issue = (3'(cnt_next) + 3'(rd_now)) < 3'd2;
   end

   // Next-state and request control
   always_comb begin
      state_next = state_q;
      addr_next  = addr_q;
      rem_next   = rem_q;
      tok_acc    = I_FTk_v & ((state_q == IDLE) | (state_q == STORE));
      st_acc     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      issue_addr = addr_q;
      err        = 1'b0;

      case (state_q)
         IDLE: begin
            if (tok_acc) begin
               if (!I_FTk_a || (hdr_len == '0)) begin
                  err = 1'b1;
               end else if (hdr_we) begin
                  state_next = STORE;
                  addr_next  = hdr_base;
                  rem_next   = hdr_len;
               end else begin
                  // First read goes out with the header so data is back at t+3
                  state_next = LOAD;
                  issue      = 1'b1;
                  issue_addr = hdr_base;
                  issue_last = (hdr_len == LEN_W'(1));
                  addr_next  = WIDTH_ADDR'(hdr_base + WIDTH_ADDR'(1));
                  rem_next   = LEN_W'(hdr_len - LEN_W'(1));
               end
            end
         end
         STORE: begin
            if (tok_acc) begin
               st_acc    = 1'b1;
               addr_next = WIDTH_ADDR'(addr_q + WIDTH_ADDR'(1));
               rem_next  = LEN_W'(rem_q - LEN_W'(1));
               if (rem_q == LEN_W'(1)) begin
                  state_next = IDLE;
               end else if (I_FTk_r) begin
                  state_next = IDLE;
                  err        = 1'b1;
               end
            end
         end
         LOAD: begin
            if (rem_q == '0) begin
               state_next = DRAIN;
            end else if (can_issue) begin
               issue      = 1'b1;
               issue_last = (rem_q == LEN_W'(1));
               addr_next  = WIDTH_ADDR'(addr_q + WIDTH_ADDR'(1));
               rem_next   = LEN_W'(rem_q - LEN_W'(1));
               if (rem_q == LEN_W'(1)) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer && O_FTk_r) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_next;
   end

   // Control, BRAM command and output token registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q        <= '0;
         rem_q         <= '0;
         mem_last_q    <= 1'b0;
         rd_ret_q      <= 1'b0;
         rd_ret_last_q <= 1'b0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         cnt_q         <= '0;
         O_BTk_n       <= 1'b0;
         O_Busy        <= 1'b0;
         O_Err         <= 1'b0;
         O_Mem_En      <= 1'b0;
         O_Mem_We      <= 1'b0;
         O_Mem_Addr    <= '0;
         O_Mem_Wd      <= '0;
         O_FTk_v       <= 1'b0;
         O_FTk_r       <= 1'b0;
         O_FTk_d       <= '0;
      end else begin
         addr_q        <= addr_next;
         rem_q         <= rem_next;
         O_BTk_n       <= (state_next == LOAD) | (state_next == DRAIN);
         O_Busy        <= (state_next != IDLE);
         O_Err         <= err;
         O_Mem_En      <= issue | st_acc;
         O_Mem_We      <= st_acc;
         mem_last_q    <= issue_last;
         if (issue)       O_Mem_Addr <= issue_addr;
         else if (st_acc) O_Mem_Addr <= addr_q;
         if (st_acc)      O_Mem_Wd   <= I_FTk_d;

         // Tag travels with the read so the data and its last flag arrive together
         rd_ret_q      <= rd_now;
         rd_ret_last_q <= mem_last_q;

         cnt_q <= cnt_next;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;

         if (out_free) begin
            if (pop) begin
               O_FTk_v <= 1'b1;
               O_FTk_r <= fifo_q[rd_ptr_q].last;
               O_FTk_d <= fifo_q[rd_ptr_q].data;
            end else if (bypass) begin
               O_FTk_v <= 1'b1;
               O_FTk_r <= rd_ret_last_q;
               O_FTk_d <= I_Mem_Rd;
            end else begin
               O_FTk_v <= 1'b0;
               O_FTk_r <= 1'b0;
            end
         end
      end
   end

   // FIFO storage; occupancy is tracked by cnt_q, so contents need no reset
   always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= '{last: rd_ret_last_q, data: I_Mem_Rd};
   end

endmodule
